// File: rtl/spi_slave_nrf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spi_slave_nrf
// Description : nRF-style SPI mode-0 slave with an internal 32x8 register file.
//               Optional macro SPI_SLV_BURST_EN enables address auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_nrf #(
  parameter logic [7:0] STATUS_RST = 8'h0E,
  parameter logic [7:0] CFG_RST    = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       csn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       wr_valid,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err
);

`ifdef SPI_SLV_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DATA   = 2'd2,
    IGNORE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic       sck_s1, sck_s2, sck_prev;
  logic       csn_s1, csn_s2, csn_prev;
  logic       mosi_s1, mosi_s2;
  logic [1:0] settle;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic [4:0] addr;
  logic       is_write;
  logic [7:0] regs [32];

  logic       sck_rise, sck_fall, csn_rise, csn_fall;
  logic       start, stop, byte_done;
  logic [7:0] rx_byte, tx_load;

  // A frame may only start once csn has been seen high after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      csn_s1   <= 1'b1;
      csn_s2   <= 1'b1;
      csn_prev <= 1'b1;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      settle   <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sck_s1   <= sck;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      csn_s1   <= csn;
      csn_s2   <= csn_s1;
      csn_prev <= csn_s2;
      mosi_s1  <= mosi;
      mosi_s2  <= mosi_s1;
      settle   <= {settle[0], 1'b1};
      if (settle[1] && csn_s2)
        armed <= 1'b1;
    end
  end

  assign sck_rise  = sck_s2 & ~sck_prev;
  assign sck_fall  = ~sck_s2 & sck_prev;
  assign csn_rise  = csn_s2 & ~csn_prev;
  assign csn_fall  = ~csn_s2 & csn_prev;
  assign start     = (state == IDLE) && armed && csn_fall;
  assign stop      = (state != IDLE) && csn_rise;
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi_s2};
  assign tx_load   = (state == DATA && !is_write) ? regs[addr] : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMD;
      CMD:     if (byte_done) state_nxt = (rx_byte[7:6] == 2'b00) ? DATA : IGNORE;
      DATA:    if (byte_done && !BURST) state_nxt = IGNORE;
      default: state_nxt = state;
    endcase
    if (stop)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'd0;
      tx_sr     <= 8'h00;
      addr      <= 5'd0;
      is_write  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= 8'h00;
      wr_valid  <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 8'h00;
      frame_err <= 1'b0;
      for (int i = 0; i < 32; i++)
        regs[i] <= 8'h00;
      regs[0] <= CFG_RST;
      regs[7] <= STATUS_RST;
    end else begin
      cmd_valid <= 1'b0;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (stop) begin
        bit_cnt <= 3'd0;
        tx_sr   <= 8'h00;
        if (bit_cnt != 3'd0)
          frame_err <= 1'b1;
      end else if (start) begin
        bit_cnt <= 3'd0;
        tx_sr   <= regs[7];
      end else if (state != IDLE) begin
        if (sck_rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done && state == CMD) begin
            cmd_byte  <= rx_byte;
            cmd_valid <= 1'b1;
            addr      <= rx_byte[4:0];
            is_write  <= rx_byte[5];
          end else if (byte_done && state == DATA) begin
            if (is_write) begin
              wr_valid <= 1'b1;
              wr_addr  <= addr;
              wr_data  <= rx_byte;
              // STATUS is write-one-to-clear on its interrupt flags only.
              if (addr == 5'd7)
                regs[7] <= regs[7] & ~(rx_byte & 8'h70);
              else
                regs[addr] <= rx_byte;
            end
            addr <= addr + 5'd1;
          end
        end else if (sck_fall) begin
          // A falling edge with the counter at 0 follows a completed byte.
          if (bit_cnt == 3'd0)
            tx_sr <= tx_load;
          else
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

  assign miso    = tx_sr[7] & ((state == CMD) || (state == DATA));
  assign miso_oe = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_nrf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_slave_nrf
// Description : Frame-level randomized bench for spi_slave_nrf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_nrf;

`ifdef SPI_SLV_BURST_EN
  localparam bit BURST_MODEL = 1'b1;
`else
  localparam bit BURST_MODEL = 1'b0;
`endif
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset, sck, csn, mosi;
  logic       miso, miso_oe, cmd_valid, wr_valid, frame_err;
  logic [7:0] cmd_byte, wr_data;
  logic [4:0] wr_addr;
  logic       miso2, oe2, cv2, wv2, fe2;
  logic [7:0] cb2, wd2;
  logic [4:0] wa2;

  always #5 clk = ~clk;

  spi_slave_nrf dut (
    .clk(clk), .reset(reset), .sck(sck), .csn(csn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  spi_slave_nrf #(.STATUS_RST(8'h7E)) dut2 (
    .clk(clk), .reset(reset), .sck(sck), .csn(csn), .mosi(mosi),
    .miso(miso2), .miso_oe(oe2), .cmd_valid(cv2), .cmd_byte(cb2),
    .wr_valid(wv2), .wr_addr(wa2), .wr_data(wd2), .frame_err(fe2)
  );

  int total = 0;
  int bad = 0;

  int cmd_cnt = 0, err_cnt = 0, wr_cnt = 0;
  logic [4:0] log_a [512];
  logic [7:0] log_d [512];

  always @(negedge clk) begin
    if (cmd_valid) cmd_cnt <= cmd_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (wr_valid) begin
      log_a[wr_cnt] <= wr_addr;
      log_d[wr_cnt] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Frame description and captured/expected results
  logic [7:0] f_tx [4];
  logic [7:0] f_rx [4];
  logic [7:0] f_rx2 [4];
  int         f_n, f_bits;
  logic [7:0] mdl0 [32];
  logic [7:0] mdl1 [32];
  logic [7:0] exp_rx [4];
  logic [7:0] exp_rx2 [4];
  logic       chk [4];
  logic [4:0] exp_wa [4];
  logic [7:0] exp_wd [4];
  int         exp_nwr;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mdl0[i] = 8'h00;
      mdl1[i] = 8'h00;
    end
    mdl0[0] = 8'h08; mdl1[0] = 8'h08;
    mdl0[7] = 8'h0E; mdl1[7] = 8'h7E;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [7:0] d);
    if (a == 5'd7) begin
      mdl0[7] = mdl0[7] & ~(d & 8'h70);
      mdl1[7] = mdl1[7] & ~(d & 8'h70);
    end else begin
      mdl0[a] = d;
      mdl1[a] = d;
    end
  endtask

  // Expected results of the frame in f_tx/f_n/f_bits; updates the model.
  task automatic model_frame();
    logic [4:0] a;
    logic full, take;
    exp_nwr = 0;
    for (int k = 0; k < 4; k++) begin
      exp_rx[k] = 8'h00; exp_rx2[k] = 8'h00; chk[k] = 1'b0;
    end
    exp_rx[0] = mdl0[7]; exp_rx2[0] = mdl1[7]; chk[0] = 1'b1;
    a = f_tx[0][4:0];
    for (int k = 1; k < f_n; k++) begin
      full = (k != f_n - 1) || (f_bits == 8);
      take = BURST_MODEL || (k == 1);
      case (f_tx[0][7:5])
        3'b000: begin
          chk[k] = full;
          if (take) begin exp_rx[k] = mdl0[a]; exp_rx2[k] = mdl1[a]; end
        end
        3'b001: if (take && full) begin
          exp_wa[exp_nwr] = a; exp_wd[exp_nwr] = f_tx[k];
          exp_nwr++;
          model_write(a, f_tx[k]);
        end
        default: chk[k] = full;
      endcase
      a = a + 5'd1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb,
                           output logic [7:0] r, output logic [7:0] r2);
    r = 8'h00; r2 = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      r  = {r[6:0], miso};
      r2 = {r2[6:0], miso2};
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame();
    logic [7:0] r, r2;
    csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < f_n; k++) begin
      send_bits(f_tx[k], (k == f_n - 1) ? f_bits : 8, r, r2);
      f_rx[k] = r; f_rx2[k] = r2;
    end
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int n);
    f_tx[0] = b0; f_tx[1] = b1; f_tx[2] = b2; f_tx[3] = 8'h00;
    f_n = n; f_bits = 8;
  endtask

  task automatic test_reset();
    reset = 1'b1; csn = 1'b1; sck = 1'b0; mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({miso, miso_oe, cmd_valid, cmd_byte, wr_valid, wr_addr, wr_data, frame_err} !== 26'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {miso, miso_oe, cmd_valid, cmd_byte, wr_valid, wr_addr, wr_data, frame_err});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({miso, miso_oe} !== 2'b00) begin
      bad++; $display("FAIL idle_miso got=%b want=00", {miso, miso_oe});
    end
  endtask

  task automatic test_read_config();
    int c0, w0;
    c0 = cmd_cnt; w0 = wr_cnt;
    set_frame(8'h00, 8'hFF, 8'h00, 2);
    model_frame(); spi_frame();
    total++; if (f_rx[0] !== 8'h0E) begin bad++; $display("FAIL rd_cfg_status got=%h want=0e", f_rx[0]); end
    total++; if (f_rx[1] !== 8'h08) begin bad++; $display("FAIL rd_cfg_data got=%h want=08", f_rx[1]); end
    total++; if (cmd_cnt - c0 !== 1) begin bad++; $display("FAIL rd_cfg_cmdcnt got=%0d want=1", cmd_cnt - c0); end
    total++; if (cmd_byte !== 8'h00) begin bad++; $display("FAIL rd_cfg_cmdbyte got=%h want=00", cmd_byte); end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL rd_cfg_wrcnt got=%0d want=0", wr_cnt - w0); end
  endtask

  task automatic test_write_read();
    int w0;
    w0 = wr_cnt;
    set_frame(8'h25, 8'h4C, 8'h00, 2);
    model_frame(); spi_frame();
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL wr_cnt got=%0d want=1", wr_cnt - w0); end
    total++; if (log_a[w0] !== 5'd5) begin bad++; $display("FAIL wr_addr got=%h want=05", log_a[w0]); end
    total++; if (log_d[w0] !== 8'h4C) begin bad++; $display("FAIL wr_data got=%h want=4c", log_d[w0]); end
    set_frame(8'h05, 8'hFF, 8'h00, 2);
    model_frame(); spi_frame();
    total++; if (f_rx[1] !== 8'h4C) begin bad++; $display("FAIL rd_back got=%h want=4c", f_rx[1]); end
    total++; if (cmd_byte !== 8'h05) begin bad++; $display("FAIL rd_back_cmd got=%h want=05", cmd_byte); end
  endtask

  task automatic test_status_clear();
    set_frame(8'h07, 8'hFF, 8'h00, 2);
    model_frame(); spi_frame();
    total++; if (f_rx2[1] !== 8'h7E) begin bad++; $display("FAIL status_pre got=%h want=7e", f_rx2[1]); end
    set_frame(8'h27, 8'h70, 8'h00, 2);
    model_frame(); spi_frame();
    set_frame(8'h07, 8'hFF, 8'h00, 2);
    model_frame(); spi_frame();
    total++; if (f_rx2[0] !== 8'h0E) begin bad++; $display("FAIL status_post_b0 got=%h want=0e", f_rx2[0]); end
    total++; if (f_rx2[1] !== 8'h0E) begin bad++; $display("FAIL status_post got=%h want=0e", f_rx2[1]); end
    total++; if (f_rx[1] !== 8'h0E) begin bad++; $display("FAIL status_dflt got=%h want=0e", f_rx[1]); end
  endtask

  task automatic test_frame_err();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    set_frame(8'h21, 8'h5A, 8'h00, 2);
    f_bits = 5;
    model_frame(); spi_frame();
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_cnt got=%0d want=1", err_cnt - e0); end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL ferr_wr got=%0d want=0", wr_cnt - w0); end
    set_frame(8'h01, 8'hFF, 8'h00, 2);
    model_frame(); spi_frame();
    total++; if (f_rx[1] !== 8'h00) begin bad++; $display("FAIL ferr_reg got=%h want=00", f_rx[1]); end
  endtask

  task automatic test_burst();
    int w0;
    w0 = wr_cnt;
    set_frame(8'h3F, 8'hA1, 8'hA2, 3);
    model_frame(); spi_frame();
    total++; if (wr_cnt - w0 !== exp_nwr) begin bad++; $display("FAIL burst_wrcnt got=%0d want=%0d", wr_cnt - w0, exp_nwr); end
    for (int i = 0; i < exp_nwr; i++) begin
      total++;
      if ({log_a[w0+i], log_d[w0+i]} !== {exp_wa[i], exp_wd[i]}) begin
        bad++; $display("FAIL burst_wr%0d got=%h/%h want=%h/%h", i, log_a[w0+i], log_d[w0+i], exp_wa[i], exp_wd[i]);
      end
    end
    set_frame(8'h1F, 8'hFF, 8'hFF, 3);
    model_frame(); spi_frame();
    total++; if (f_rx[1] !== 8'hA1) begin bad++; $display("FAIL burst_rd1f got=%h want=a1", f_rx[1]); end
    total++; if (f_rx[2] !== exp_rx[2]) begin bad++; $display("FAIL burst_rd00 got=%h want=%h", f_rx[2], exp_rx[2]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r, r2;
    int c0, w0, e0;
    csn = 1'b0;
    repeat (8) @(negedge clk);
    send_bits(8'h25, 8, r, r2);
    send_bits(8'h4C, 4, r, r2);
    c0 = cmd_cnt; w0 = wr_cnt; e0 = err_cnt;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({miso, miso_oe, cmd_valid, cmd_byte, wr_valid, wr_addr, wr_data, frame_err} !== 26'd0) begin
      bad++; $display("FAIL midrst_outputs got=%h want=0",
        {miso, miso_oe, cmd_valid, cmd_byte, wr_valid, wr_addr, wr_data, frame_err});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    send_bits(8'h4C, 4, r, r2);
    send_bits(8'h25, 8, r, r2);
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL midrst_oe got=%b want=0", miso_oe); end
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if ({cmd_cnt - c0, wr_cnt - w0, err_cnt - e0} !== {32'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL midrst_events got cmd=%0d wr=%0d err=%0d want 0", cmd_cnt - c0, wr_cnt - w0, err_cnt - e0);
    end
    set_frame(8'h05, 8'hFF, 8'h00, 2);
    model_frame(); spi_frame();
    total++; if (f_rx[1] !== 8'h00) begin bad++; $display("FAIL midrst_reg5 got=%h want=00", f_rx[1]); end
    set_frame(8'h00, 8'hFF, 8'h00, 2);
    model_frame(); spi_frame();
    total++; if (f_rx[1] !== 8'h08) begin bad++; $display("FAIL midrst_cfg got=%h want=08", f_rx[1]); end
  endtask

  task automatic test_random();
    int c0, w0, e0, op;
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0:       f_tx[0] = {3'b000, 5'($urandom)};
        1:       f_tx[0] = {3'b001, 5'($urandom)};
        2:       f_tx[0] = {3'($urandom_range(2, 7)), 5'($urandom)};
        default: f_tx[0] = 8'hFF;
      endcase
      for (int k = 1; k < 4; k++) f_tx[k] = 8'($urandom);
      f_n = int'($urandom_range(2, 4));
      f_bits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 8;
      c0 = cmd_cnt; w0 = wr_cnt; e0 = err_cnt;
      model_frame(); spi_frame();
      for (int k = 0; k < f_n; k++) begin
        if (chk[k]) begin
          total++;
          if ({f_rx[k], f_rx2[k]} !== {exp_rx[k], exp_rx2[k]}) begin
            bad++; $display("FAIL rnd%0d_miso%0d cmd=%h got=%h/%h want=%h/%h", t, k, f_tx[0], f_rx[k], f_rx2[k], exp_rx[k], exp_rx2[k]);
          end
        end
      end
      total++;
      if (cmd_cnt - c0 !== 1 || cmd_byte !== f_tx[0]) begin
        bad++; $display("FAIL rnd%0d_cmd got=%0d/%h want=1/%h", t, cmd_cnt - c0, cmd_byte, f_tx[0]);
      end
      total++;
      if (wr_cnt - w0 !== exp_nwr) begin
        bad++; $display("FAIL rnd%0d_wrcnt got=%0d want=%0d", t, wr_cnt - w0, exp_nwr);
      end
      for (int i = 0; i < exp_nwr; i++) begin
        total++;
        if ({log_a[w0+i], log_d[w0+i]} !== {exp_wa[i], exp_wd[i]}) begin
          bad++; $display("FAIL rnd%0d_wr%0d got=%h/%h want=%h/%h", t, i, log_a[w0+i], log_d[w0+i], exp_wa[i], exp_wd[i]);
        end
      end
      total++;
      if (err_cnt - e0 !== ((f_bits != 8) ? 1 : 0)) begin
        bad++; $display("FAIL rnd%0d_ferr got=%0d want=%0d", t, err_cnt - e0, (f_bits != 8) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_config();
    test_write_read();
    test_status_clear();
    test_frame_err();
    test_burst();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_nrf.md
SPI_SLAVE_NRF -- requirements
Module: spi_slave_nrf

Interface
REQ-001 Parameter STATUS_RST, default 8'h0E; reset value of register 0x07, STATUS.
REQ-002 Parameter CFG_RST, default 8'h08; reset value of register 0x00, CONFIG.
REQ-003 clk  input  1  system clock; its frequency SHALL be at least 8x the SCK frequency.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sck  input  1  SPI clock from the master, mode 0, asynchronous to clk.
REQ-006 csn  input  1  chip select, active low, asynchronous to clk.
REQ-007 mosi  input  1  master-out data.
REQ-008 miso  output  1  slave-out data.
REQ-009 miso_oe  output  1  MISO output enable; high only while csn is low after synchronisation.
REQ-010 cmd_valid  output  1  one-clk pulse when a command byte has been received.
REQ-011 cmd_byte  output  8  last received command byte; held until the next cmd_valid.
REQ-012 wr_valid  output  1  one-clk pulse per register write.
REQ-013 wr_addr  output  5  register address for the current wr_valid.
REQ-014 wr_data  output  8  register data for the current wr_valid.
REQ-015 frame_err  output  1  one-clk pulse when csn rises in the middle of a byte.

Function
REQ-016 sck, csn and mosi SHALL each pass through a 2-flop synchroniser; edge detection SHALL use the synchronised sck and its previous value.
REQ-017 FSM states SHALL be IDLE, CMD, DATA and IGNORE; reset enters IDLE.
REQ-018 IDLE->CMD on the synchronised csn falling edge. On that same cycle, load the TX shift register with register 0x07 and drive miso with bit 7, MSB first.
REQ-019 Sampling: on each synchronised sck rising edge, shift mosi into the RX register and increment the 3-bit bit counter.
REQ-020 Shifting out: on each synchronised sck falling edge, shift the next TX bit onto miso.
REQ-021 When the bit counter wraps from 7 to 0 in CMD, latch cmd_byte and pulse cmd_valid, then decode the command:
  - 000AAAAA: read; TX register loaded with reg[A] before the next falling edge; state->DATA.
  - 001AAAAA: write; state->DATA.
  - 8'hFF: NOP; state->IGNORE.
  - any other value: state->IGNORE.
REQ-022 DATA write: when a byte completes, pulse wr_valid and update reg[A] on the same clk. Writes to 0x07 SHALL clear the bits written as 1 (bits 6:4 only); other bits are unaffected.
REQ-023 In IGNORE, miso SHALL be 0 and no register SHALL change.
REQ-024 Any state->IDLE on the synchronised csn rising edge. If the bit counter is not 0, pulse frame_err and discard the partial byte without writing.
REQ-025 When csn is high, miso SHALL be 0, miso_oe 0 and the bit counter 0.
REQ-026 The register file SHALL be 32x8 and internal. Addresses other than 0x00 and 0x07 SHALL reset to 0x00.
REQ-027 Latency: cmd_valid and wr_valid SHALL assert at most 4 clk after the synchronised-input sck rising edge of bit 0.

Reset
REQ-028 Reset SHALL force the following, asynchronously and including in the middle of a frame:
  - FSM to IDLE.
  - miso=0, miso_oe=0, cmd_valid=0, cmd_byte=8'h00, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0.
  - Register file to its reset values.
  - Synchronisers to csn=1, sck=0.
REQ-029 After reset deasserts with csn already low, the block SHALL wait for a csn rising edge and then a falling edge before starting a frame.

Configuration
REQ-030 Macro SPI_SLV_BURST_EN: when defined, each further data byte in DATA SHALL auto-increment A (5-bit, 0x1F wraps to 0x00), for both reads and writes.
REQ-031 When SPI_SLV_BURST_EN is undefined, DATA->IGNORE after the first data byte: extra bytes read 8'h00 and write nothing.

Verification
REQ-032 Reset, then frame 8'h00,8'hFF -> miso bytes 8'h0E, 8'h08; cmd_valid once, cmd_byte=8'h00; no wr_valid.
REQ-033 Frame 8'h25,8'h4C -> wr_valid once with wr_addr=5, wr_data=8'h4C; a following read frame 8'h05,8'hFF returns 8'h4C.
REQ-034 Frame 8'h27,8'h70 with STATUS=8'h7E -> STATUS becomes 8'h0E.
REQ-035 csn rises after 5 bits of the data byte of 8'h21 -> frame_err pulse; no wr_valid; reg 0x01 unchanged.
REQ-036 With SPI_SLV_BURST_EN, frame 8'h3F,8'hA1,8'hA2 -> writes 0x1F=A1, 0x00=A2. Without the macro -> only 0x1F=A1.
REQ-037 Assert reset in the middle of a write byte -> all outputs at reset values within 1 clk; no wr_valid; registers at reset values.
